feed_gen: RTL and testbench
===========================

FEED_GEN -- requirements
Module: feed_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- K, 2, hidden units per tree parity machine.
- N, 3, inputs per hidden unit.
- LFSR_W, 13, LFSR width; fixed, no other value supported.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1, single clock; all state changes on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- seed_no, input, 3, seed table index, sampled only while seed_load=1.
- seed_load, input, 1, load seed and abort any operation in progress.
- req, input, 1, consumer request for one new input vector.
- ack, input, 1, consumer accepts the vector currently presented.
- feed, output, K*N, packed input vector; stable while feed_valid=1.
- feed_valid, output, 1, feed holds a complete, unconsumed vector.
- busy, output, 1, high in SHIFT state.
- vec_count, output, 32, count of vectors accepted since reset or seed load.

Function
REQ-003 The block SHALL contain a 13-bit Fibonacci LFSR with polynomial x^13+x^4+x^3+x+1.
- Step: fb = s[12]^s[3]^s[2]^s[0]; s <= {s[11:0], fb}.
REQ-004 Seed table SHALL be:
- 0: 13'h1ACE; 1: 13'h0BEE; 2: 13'h1234; 3: 13'h0F0F.
- 4: 13'h1555; 5: 13'h0AAA; 6: 13'h1C3A; 7: 13'h0000.
REQ-005 Lock-up guard: a seed value of zero SHALL be loaded as 13'h0001.
REQ-006 The FSM SHALL have exactly three states: IDLE, SHIFT, VALID.
REQ-007 IDLE with req=1 at an edge SHALL enter SHIFT and clear the bit counter to 0.
REQ-008 IDLE with req=0 SHALL remain in IDLE.
REQ-009 Each SHIFT cycle SHALL perform all of the following:
- Capture output bit s[12] (pre-step value) via feed <= {feed[K*N-2:0], s[12]}.
- Step the LFSR once.
- Increment the bit counter.
REQ-010 On the SHIFT edge with bit counter = K*N-1, the FSM SHALL enter VALID and set feed_valid=1.
- Latency: req sampled at edge t gives feed_valid=1 after edge t+K*N (6 cycles at defaults).
REQ-011 In VALID, feed and the LFSR SHALL hold.
REQ-012 VALID with ack=0 SHALL hold VALID indefinitely.
REQ-013 VALID with ack=1 and req=0 SHALL:
- Enter IDLE.
- Clear feed_valid.
- Increment vec_count by 1.
REQ-014 VALID with ack=1 and req=1 SHALL:
- Increment vec_count.
- Clear feed_valid.
- Enter SHIFT with bit counter 0 (back-to-back vector, no IDLE cycle).
REQ-015 Ignored inputs SHALL have no effect:
- req while in SHIFT or VALID (except as in REQ-014).
- ack outside VALID.
REQ-016 seed_load=1 SHALL take priority over all other inputs in any state:
- LFSR loaded per REQ-004/REQ-005.
- feed cleared to 0; feed_valid=0.
- vec_count cleared to 0.
- Bit counter cleared; FSM enters IDLE.
REQ-017 vec_count SHALL wrap from 32'hFFFFFFFF to 0 without any flag.
REQ-018 busy SHALL be 1 exactly when the FSM is in SHIFT.

Reset
REQ-019 rst=0 SHALL asynchronously force all of the following, independent of clk:
- LFSR = 13'h1ACE (seed 0); FSM = IDLE; bit counter = 0.
- feed = 0, feed_valid = 0, busy = 0, vec_count = 0.
REQ-020 Reset asserted mid-SHIFT or mid-VALID SHALL discard the partial or pending vector with no vec_count increment.
REQ-021 The first req after rst deasserts SHALL be honoured at the first rising edge on which it is sampled.

Verification
REQ-022 The bench SHALL cover at least the following directed scenarios:
- Reset, then one-cycle req pulse -> busy=1 for 6 cycles; feed_valid=1 with feed=6'b110101; internal LFSR = 13'h13AC.
- Hold ack=0 for 20 cycles in VALID -> feed stays 6'b110101, feed_valid stays 1, vec_count stays 0; then ack pulse -> feed_valid=0, vec_count=1.
- req=1 and ack=1 held continuously -> a new vector every 7 cycles; vec_count increments once per vector; no IDLE cycle between vectors.
- seed_load with seed_no=7 during SHIFT -> LFSR=13'h0001, feed=0, feed_valid=0, vec_count=0, FSM IDLE; next vector completes normally.
- rst pulsed low mid-SHIFT (bit counter=3) -> all outputs 0 immediately; after release, a req reproduces feed=6'b110101.
- Preload vec_count near wrap via 2^32 acks (or a force), one more ack -> vec_count=0.

Source files
------------

// File: rtl/feed_gen.sv
`default_nettype none
// ============================================================================
// Module      : feed_gen
// Description : Input-vector generator for tree parity machines. A 13-bit
//               Fibonacci LFSR (x^13+x^4+x^3+x+1) is shifted out MSB-first,
//               one bit per cycle, into a K*N-bit vector. The vector is then
//               presented to a consumer under a req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module feed_gen #(
  parameter int K      = 2,
  parameter int N      = 3,
  parameter int LFSR_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       seed_no,
  input  logic             seed_load,
  input  logic             req,
  input  logic             ack,
  output logic [K*N-1:0]   feed,
  output logic             feed_valid,
  output logic             busy,
  output logic [31:0]      vec_count
);

  localparam int FEED_W = K * N;
  localparam int CNT_W  = (FEED_W > 1) ? $clog2(FEED_W) : 1;
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(FEED_W - 1);
  localparam logic [LFSR_W-1:0] C_RESET_SEED = LFSR_W'(13'h1ACE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [FEED_W-1:0]   feed_q, feed_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         vec_count_q, vec_count_d;

  logic [LFSR_W-1:0]   w_seed_raw;
  logic [LFSR_W-1:0]   w_seed_val;
  logic                w_fb;
  logic [LFSR_W-1:0]   w_lfsr_next;

  // Seed table lookup; a zero seed would lock the LFSR, so it is replaced by 1
  always_comb begin
    w_seed_raw = '0;
    case (seed_no)
      3'd0:    w_seed_raw = LFSR_W'(13'h1ACE);
      3'd1:    w_seed_raw = LFSR_W'(13'h0BEE);
      3'd2:    w_seed_raw = LFSR_W'(13'h1234);
      3'd3:    w_seed_raw = LFSR_W'(13'h0F0F);
      3'd4:    w_seed_raw = LFSR_W'(13'h1555);
      3'd5:    w_seed_raw = LFSR_W'(13'h0AAA);
      3'd6:    w_seed_raw = LFSR_W'(13'h1C3A);
      default: w_seed_raw = LFSR_W'(13'h0000);
    endcase
    w_seed_val = (w_seed_raw == '0) ? LFSR_W'(1) : w_seed_raw;
  end

  // One Fibonacci LFSR step: taps at 12, 3, 2, 0, shift toward the MSB
  always_comb begin
    w_fb        = lfsr_q[LFSR_W-1] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0];
    w_lfsr_next = {lfsr_q[LFSR_W-2:0], w_fb};
  end

  // Next-state and datapath update; seed_load overrides every state
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    feed_d      = feed_q;
    cnt_d       = cnt_q;
    vec_count_d = vec_count_q;

    if (seed_load) begin
      lfsr_d      = w_seed_val;
      feed_d      = '0;
      vec_count_d = '0;
      cnt_d       = '0;
      state_d     = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          // Capture the pre-step MSB, then advance the generator
          feed_d = (feed_q << 1) | FEED_W'(lfsr_q[LFSR_W-1]);
          lfsr_d = w_lfsr_next;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == C_CNT_LAST) begin
            state_d = VALID;
          end
        end
        VALID: begin
          if (ack) begin
            vec_count_d = vec_count_q + 32'd1;
            cnt_d       = '0;
            // A pending req starts the next vector without passing IDLE
            state_d     = req ? SHIFT : IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lfsr_q      <= C_RESET_SEED;
      feed_q      <= '0;
      cnt_q       <= '0;
      vec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      feed_q      <= feed_d;
      cnt_q       <= cnt_d;
      vec_count_q <= vec_count_d;
    end
  end

  assign feed       = feed_q;
  assign feed_valid = (state_q == VALID);
  assign busy       = (state_q == SHIFT);
  assign vec_count  = vec_count_q;

endmodule
`default_nettype wire

// File: tb/tb_feed_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_feed_gen
// Description : Directed self-checking bench for feed_gen (defaults K=2, N=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_feed_gen;

  logic        clk;
  logic        rst;
  logic [2:0]  seed_no;
  logic        seed_load;
  logic        req;
  logic        ack;
  logic [5:0]  feed;
  logic        feed_valid;
  logic        busy;
  logic [31:0] vec_count;

  int n_pass  = 0;
  int n_total = 0;

  feed_gen #(.K(2), .N(3), .LFSR_W(13)) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_no   (seed_no),
    .seed_load (seed_load),
    .req       (req),
    .ack       (ack),
    .feed      (feed),
    .feed_valid(feed_valid),
    .busy      (busy),
    .vec_count (vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (at negedges) until feed_valid, bounded by a cycle budget
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (feed_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; seed_no = 3'd0; seed_load = 1'b0; req = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (feed !== 6'd0) $display("FAIL reset_feed got=%b exp=%b", feed, 6'd0); else n_pass++;
    n_total++; if (feed_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", feed_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (vec_count !== 32'd0) $display("FAIL reset_count got=%0d exp=0", vec_count); else n_pass++;
    n_total++; if (dut.lfsr_q !== 13'h1ACE) $display("FAIL reset_lfsr got=%h exp=1ace", dut.lfsr_q); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_single_vector();
    int busy_cycles;
    bit ok;
    busy_cycles = 0;
    ok = 1'b0;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (feed_valid) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    n_total++; if (!ok) $display("FAIL single_timeout got=no_valid exp=valid"); else n_pass++;
    n_total++; if (busy_cycles != 6) $display("FAIL single_busy_cycles got=%0d exp=6", busy_cycles); else n_pass++;
    n_total++; if (feed !== 6'b110101) $display("FAIL single_feed got=%b exp=110101", feed); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy_in_valid got=%b exp=0", busy); else n_pass++;
    n_total++; if (dut.lfsr_q !== 13'h13AC) $display("FAIL single_lfsr got=%h exp=13ac", dut.lfsr_q); else n_pass++;
  endtask

  task automatic test_hold_ack();
    int bad;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (feed !== 6'b110101 || feed_valid !== 1'b1 || vec_count !== 32'd0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL hold_stable got=%0d_bad_cycles exp=0", bad); else n_pass++;
    ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    n_total++; if (feed_valid !== 1'b0) $display("FAIL hold_ack_valid got=%b exp=0", feed_valid); else n_pass++;
    n_total++; if (vec_count !== 32'd1) $display("FAIL hold_ack_count got=%0d exp=1", vec_count); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL hold_ack_idle got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_ack_ignored();
    ack = 1'b1;
    repeat (3) @(negedge clk);
    ack = 1'b0;
    n_total++; if (vec_count !== 32'd1) $display("FAIL idle_ack_count got=%0d exp=1", vec_count); else n_pass++;
    n_total++; if (busy !== 1'b0 || feed_valid !== 1'b0) $display("FAIL idle_ack_state got=%b%b exp=00", busy, feed_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int valid_at[$];
    int idle_seen;
    logic [5:0] first_feed;
    bit ok;
    idle_seen = 0;
    first_feed = '0;
    req = 1'b1; ack = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (feed_valid) begin
        if (valid_at.size() == 0) first_feed = feed;
        valid_at.push_back(i);
      end
      if (!busy && !feed_valid) idle_seen++;
    end
    req = 1'b0; ack = 1'b0;
    n_total++; if (valid_at.size() != 3) $display("FAIL b2b_nvec got=%0d exp=3", valid_at.size()); else n_pass++;
    if (valid_at.size() == 3) begin
      n_total++;
      if (valid_at[0] != 7 || valid_at[1] != 14 || valid_at[2] != 21)
        $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=7,14,21", valid_at[0], valid_at[1], valid_at[2]);
      else n_pass++;
    end
    n_total++; if (first_feed !== 6'b100111) $display("FAIL b2b_feed got=%b exp=100111", first_feed); else n_pass++;
    n_total++; if (idle_seen != 0) $display("FAIL b2b_idle got=%0d exp=0", idle_seen); else n_pass++;
    n_total++; if (vec_count !== 32'd4) $display("FAIL b2b_count got=%0d exp=4", vec_count); else n_pass++;
    wait_valid(ok);
    n_total++; if (!ok) $display("FAIL b2b_drain_timeout got=no_valid exp=valid"); else n_pass++;
    ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    n_total++; if (vec_count !== 32'd5) $display("FAIL b2b_final_count got=%0d exp=5", vec_count); else n_pass++;
  endtask

  task automatic test_seed_load();
    bit ok;
    req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    n_total++; if (busy !== 1'b1) $display("FAIL seed_pre_shift got=%b exp=1", busy); else n_pass++;
    seed_no = 3'd7; seed_load = 1'b1;
    @(negedge clk); seed_load = 1'b0; seed_no = 3'd0;
    n_total++; if (dut.lfsr_q !== 13'h0001) $display("FAIL seed_lfsr got=%h exp=0001", dut.lfsr_q); else n_pass++;
    n_total++; if (feed !== 6'd0 || feed_valid !== 1'b0) $display("FAIL seed_feed got=%b/%b exp=000000/0", feed, feed_valid); else n_pass++;
    n_total++; if (vec_count !== 32'd0) $display("FAIL seed_count got=%0d exp=0", vec_count); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL seed_idle got=%b exp=0", busy); else n_pass++;
    req = 1'b1;
    @(negedge clk); req = 1'b0;
    wait_valid(ok);
    n_total++; if (!ok) $display("FAIL seed_vec_timeout got=no_valid exp=valid"); else n_pass++;
    n_total++; if (feed !== 6'b000000) $display("FAIL seed_vec_feed got=%b exp=000000", feed); else n_pass++;
    n_total++; if (dut.lfsr_q !== 13'h0071) $display("FAIL seed_vec_lfsr got=%h exp=0071", dut.lfsr_q); else n_pass++;
    ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    n_total++; if (vec_count !== 32'd1) $display("FAIL seed_vec_count got=%0d exp=1", vec_count); else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    req = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (dut.cnt_q !== 3'd3) $display("FAIL rstmid_cnt got=%0d exp=3", dut.cnt_q); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++;
    if (feed !== 6'd0 || feed_valid !== 1'b0 || busy !== 1'b0 || vec_count !== 32'd0)
      $display("FAIL rstmid_outputs got=%b/%b/%b/%0d exp=000000/0/0/0", feed, feed_valid, busy, vec_count);
    else n_pass++;
    n_total++; if (dut.lfsr_q !== 13'h1ACE) $display("FAIL rstmid_lfsr got=%h exp=1ace", dut.lfsr_q); else n_pass++;
    @(negedge clk); rst = 1'b1;
    req = 1'b1;
    @(negedge clk); req = 1'b0;
    wait_valid(ok);
    n_total++; if (!ok) $display("FAIL rstmid_timeout got=no_valid exp=valid"); else n_pass++;
    n_total++; if (feed !== 6'b110101) $display("FAIL rstmid_feed got=%b exp=110101", feed); else n_pass++;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.vec_count_q = 32'hFFFF_FFFF;
    #1 release dut.vec_count_q;
    n_total++; if (vec_count !== 32'hFFFF_FFFF) $display("FAIL wrap_preload got=%h exp=ffffffff", vec_count); else n_pass++;
    ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    n_total++; if (vec_count !== 32'd0) $display("FAIL wrap_count got=%h exp=00000000", vec_count); else n_pass++;
    n_total++; if (feed_valid !== 1'b0) $display("FAIL wrap_valid got=%b exp=0", feed_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_hold_ack();
    test_ack_ignored();
    test_back_to_back();
    test_seed_load();
    test_reset_mid_shift();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
